// File: rtl/univ_ff_pkg.sv
// univ_ff_pkg
// Shared definitions for the universal flip-flop bank.
//   mode_t : 2-bit cell function select
//            MODE_JK = 2'b00, MODE_D = 2'b01, MODE_T = 2'b10, MODE_SR = 2'b11
package univ_ff_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_t;

endpackage

// File: rtl/univ_ff_cell.sv
// univ_ff_cell
// One storage bit that acts as a JK, D, T or SR flip-flop depending on mode.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous active-low reset
//   en      in  update enable (0 = hold)
//   mode    in  cell function (mode_t)
//   a       in  J / D / T / S
//   b       in  K / R (ignored in D and T)
//   rst_val in  value loaded on reset
//   q       out registered state
//   nxt     out state this cell will take on the next edge if not reset;
//               equals q whenever the cell holds, so the bank can compare
//               nxt against q to detect change events
module univ_ff_cell
  import univ_ff_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_t mode,
  input  logic  a,
  input  logic  b,
  input  logic  rst_val,
  output logic  q,
  output logic  nxt
);

  logic state_q;

  // Next-state function. Holding is the default so that en=0 and the
  // illegal SR 11 combination both leave the cell untouched.
  always_comb begin
    nxt = state_q;
    if (en) begin
      case (mode)
        MODE_JK: begin
          case ({a, b})
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11:   nxt = ~state_q;
            default: nxt = state_q;
          endcase
        end
        MODE_D:  nxt = a;
        MODE_T:  nxt = state_q ^ a;
        MODE_SR: begin
          case ({a, b})
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            default: nxt = state_q;
          endcase
        end
        default: nxt = state_q;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= rst_val;
    end else begin
      state_q <= nxt;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/univ_ff_bank.sv
// univ_ff_bank
// Bank of WIDTH universal flip-flop cells sharing clock, reset and mode,
// plus a saturating counter of edges on which the bank contents change.
// Optional macro SR_ERR_DET_EN adds a sticky err flag raised when any cell
// sees the illegal SR input 11 while enabled.
// Parameters:
//   WIDTH   number of cells
//   RST_VAL value loaded into q on reset
//   CNT_W   width of chg_cnt
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous active-low reset
//   en      in  update enable (0 = all cells hold)
//   mode    in  00 JK, 01 D, 10 T, 11 SR
//   a, b    in  per-cell inputs
//   q       out registered state
//   qn      out ~q
//   chg_cnt out saturating count of edges on which q changed
//   err     out sticky SR-conflict flag (only with SR_ERR_DET_EN)
module univ_ff_bank
  import univ_ff_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
`ifdef SR_ERR_DET_EN
  output logic             err,
`endif
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_t            modeSel;
  logic [WIDTH-1:0] qBus;
  logic [WIDTH-1:0] nxtBus;
  logic             anyChange;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign modeSel = mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    univ_ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (modeSel),
      .a       (a[i]),
      .b       (b[i]),
      .rst_val (RST_VAL[i]),
      .q       (qBus[i]),
      .nxt     (nxtBus[i])
    );
  end

  // Cells report nxt == q whenever they hold, so a single XOR reduction
  // covers en=0, hold codes and illegal SR without extra qualification.
  assign anyChange = |(nxtBus ^ qBus);

  // Saturating increment: stop at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (anyChange && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Reset wins over counting, so reset edges never register as changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef SR_ERR_DET_EN
  logic err_q;
  logic err_d;

  // Sticky flag: once any enabled SR edge sees a=b=1 in some cell it
  // stays set until reset.
  always_comb begin
    err_d = err_q;
    if (en && (modeSel == MODE_SR) && (|(a & b))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign q       = qBus;
  assign qn      = ~qBus;
  assign chg_cnt = cnt_q;

endmodule
